// File: rtl/adat_frame_scheduler.sv
// ADAT frame scheduler: double-buffers decoded 8-slot frames and drains them as
// one sample per valid/ready beat, de-interleaving S/MUX slots into channel order.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | no beat presented; waiting for a full buffer or a capture
// ST_DRAIN | presenting beats of buffer cur_q, beat index beat_q
// ST_HOLD  | lock lost with a beat pending; last beat held until accepted
module adat_frame_scheduler #(
    parameter int WIDTH = 24,
    parameter int SLOTS = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_channels [0:7],
    input  logic [3:0]       i_user,
    input  logic [1:0]       i_sample_rate,
    input  logic             i_valid,
    input  logic             i_locked,
    output logic [WIDTH-1:0] o_data,
    output logic [2:0]       o_chan,
    output logic [3:0]       o_user,
    output logic [1:0]       o_rate,
    output logic             o_last,
    output logic             o_eof,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_overrun,
    input  logic             i_clear,
    output logic             o_flush
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam logic [2:0] BEAT_LAST = 3'(SLOTS - 1);

    state_t           state_q;
    state_t           state_d;

    logic [WIDTH-1:0] buf_a [0:7];
    logic [WIDTH-1:0] buf_b [0:7];
    logic [3:0]       user_a;
    logic [3:0]       user_b;
    logic [1:0]       rate_a;
    logic [1:0]       rate_b;
    logic             full_a;
    logic             full_b;

    logic             cur_q;
    logic [2:0]       beat_q;
    logic             lock_q;

    logic             accept;
    logic             lock_fall;
    logic             last_acc;
    logic             other_full;
    logic             release_a;
    logic             release_b;
    logic             free_a;
    logic             free_b;
    logic             cap_req;
    logic             cap_a;
    logic             cap_b;
    logic             overrun_set;
    logic             hold_enter;
    logic             discard;
    logic             have_frame;

    logic             load;
    logic             nxt_cur;
    logic [2:0]       nxt_beat;
    logic             nxt_valid;

    logic             src_in;
    logic [1:0]       src_rate;
    logic [3:0]       src_user;
    logic [2:0]       src_slot;
    logic [WIDTH-1:0] src_data;

    // Beat k of a frame maps to slot chan*S + k/N, with N = 8/S channels per instant.
    function automatic logic [2:0] beat_slot(input logic [1:0] rate, input logic [2:0] k);
        case (rate)
            2'd1:    beat_slot = {k[1:0], k[2]};
            2'd2:    beat_slot = {k[0], k[2:1]};
            default: beat_slot = k;
        endcase
    endfunction

    function automatic logic [2:0] beat_chan(input logic [1:0] rate, input logic [2:0] k);
        case (rate)
            2'd1:    beat_chan = {1'b0, k[1:0]};
            2'd2:    beat_chan = {2'b00, k[0]};
            default: beat_chan = k;
        endcase
    endfunction

    function automatic logic beat_last(input logic [1:0] rate, input logic [2:0] k);
        case (rate)
            2'd1:    beat_last = (k[1:0] == 2'd3);
            2'd2:    beat_last = k[0];
            default: beat_last = 1'b1;
        endcase
    endfunction

    assign accept      = o_valid && i_ready;
    assign lock_fall   = lock_q && !i_locked;
    assign last_acc    = (state_q == ST_DRAIN) && accept && (beat_q == BEAT_LAST);
    assign other_full  = cur_q ? full_a : full_b;
    assign release_a   = last_acc && !cur_q;
    assign release_b   = last_acc && cur_q;
    // A buffer freed by this cycle's final handshake can take this cycle's frame.
    assign free_a      = !full_a || release_a;
    assign free_b      = !full_b || release_b;
    assign cap_req     = i_valid && i_locked && (state_q != ST_HOLD);
    assign cap_a       = cap_req && free_a;
    assign cap_b       = cap_req && !free_a && free_b;
    assign overrun_set = cap_req && !free_a && !free_b;
    assign hold_enter  = (state_q == ST_DRAIN) && lock_fall && !i_ready;
    assign discard     = ((state_q != ST_HOLD) && lock_fall && (!o_valid || i_ready))
                       || ((state_q == ST_HOLD) && accept);
    assign have_frame  = full_a || full_b || cap_a;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!discard && have_frame) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (discard) begin
                    state_d = ST_IDLE;
                end else if (hold_enter) begin
                    state_d = ST_HOLD;
                end else if (last_acc && !other_full) begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (discard) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        load      = 1'b0;
        nxt_cur   = cur_q;
        nxt_beat  = beat_q;
        nxt_valid = o_valid;
        case (state_q)
            ST_IDLE: begin
                if (!discard && have_frame) begin
                    load      = 1'b1;
                    nxt_cur   = !full_a && full_b;
                    nxt_beat  = 3'd0;
                    nxt_valid = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (discard) begin
                    nxt_valid = 1'b0;
                end else if (accept) begin
                    if (beat_q != BEAT_LAST) begin
                        load     = 1'b1;
                        nxt_beat = beat_q + 3'd1;
                    end else if (other_full) begin
                        load     = 1'b1;
                        nxt_cur  = !cur_q;
                        nxt_beat = 3'd0;
                    end else begin
                        nxt_valid = 1'b0;
                    end
                end
            end
            ST_HOLD: begin
                if (discard) begin
                    nxt_valid = 1'b0;
                end
            end
            default: nxt_valid = 1'b0;
        endcase
    end

    // A load with both buffers empty can only be the frame arriving this cycle,
    // so beat 0 is taken straight from the receiver to meet one-cycle latency.
    always_comb begin
        src_in   = !full_a && !full_b;
        src_rate = nxt_cur ? rate_b : rate_a;
        src_user = nxt_cur ? user_b : user_a;
        if (src_in) begin
            src_rate = i_sample_rate;
            src_user = i_user;
        end
        src_slot = beat_slot(src_rate, nxt_beat);
        if (src_in) begin
            src_data = i_channels[src_slot];
        end else if (nxt_cur) begin
            src_data = buf_b[src_slot];
        end else begin
            src_data = buf_a[src_slot];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cur_q     <= 1'b0;
            beat_q    <= 3'd0;
            lock_q    <= 1'b0;
            full_a    <= 1'b0;
            full_b    <= 1'b0;
            o_data    <= '0;
            o_chan    <= 3'd0;
            o_user    <= 4'd0;
            o_rate    <= 2'd0;
            o_last    <= 1'b0;
            o_eof     <= 1'b0;
            o_valid   <= 1'b0;
            o_overrun <= 1'b0;
            o_flush   <= 1'b0;
        end else begin
            lock_q  <= i_locked;
            o_flush <= discard;
            o_valid <= nxt_valid;
            if (load) begin
                cur_q  <= nxt_cur;
                beat_q <= nxt_beat;
                o_data <= src_data;
                o_chan <= beat_chan(src_rate, nxt_beat);
                o_last <= beat_last(src_rate, nxt_beat);
                o_eof  <= (nxt_beat == BEAT_LAST);
                o_user <= src_user;
                o_rate <= src_rate;
            end
            if (discard) begin
                full_a <= 1'b0;
                full_b <= 1'b0;
            end else begin
                if (cap_a) begin
                    full_a <= 1'b1;
                end else if (release_a) begin
                    full_a <= 1'b0;
                end
                if (cap_b) begin
                    full_b <= 1'b1;
                end else if (release_b) begin
                    full_b <= 1'b0;
                end
            end
            if (overrun_set) begin
                o_overrun <= 1'b1;
            end else if (i_clear) begin
                o_overrun <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (cap_a) begin
            for (int i = 0; i < 8; i++) begin
                buf_a[i] <= i_channels[i];
            end
            user_a <= i_user;
            rate_a <= i_sample_rate;
        end
        if (cap_b) begin
            for (int i = 0; i < 8; i++) begin
                buf_b[i] <= i_channels[i];
            end
            user_b <= i_user;
            rate_b <= i_sample_rate;
        end
    end

endmodule
